uart_param: RTL and testbench
=============================

# uart_param

Parametrised full-duplex UART: the next-generation serial device for the processor's I/O bus. Adds configurable data width, parity and stop bits, a transmit FIFO with valid/ready handshake, glitch-rejecting receive, and per-word error flags. It sits between the core's memory-mapped I/O logic and the board's RX/TX pins.

## Interface
- CLKS_PER_BIT, default 434: clock cycles per bit period (50 MHz / 115200); legal ≥ 4.
- DATA_BITS, default 8: payload width, 5–9.
- PARITY, default 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, default 1: 1 or 2 (TX only; RX checks only the first stop bit).
- TX_FIFO_DEPTH, default 4: transmit FIFO entries, power of 2, ≥ 2.

- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous reset, active-low.
- rx  in  1  serial input, asynchronous, idle high.
- tx  out  1  serial output, registered, idle high.
- tx_data  in  DATA_BITS  word to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  FIFO not full; a word is accepted on an edge where tx_valid & tx_ready.
- tx_busy  out  1  shifter active or FIFO non-empty.
- rx_data  out  DATA_BITS  last received word; held until the next one.
- rx_valid  out  1  one-cycle pulse per received frame.
- rx_parity_err  out  1  parity mismatch on the last frame; valid with rx_valid, held until the next frame.
- rx_frame_err  out  1  stop bit sampled 0 on the last frame; same timing as rx_parity_err.

## Operation
- Reset (reset=0 at an edge):
  - tx=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_data=0, both error flags 0.
  - FIFO emptied; both FSMs go to IDLE; the bit counter and baud counter clear.
  - Any frame in progress is abandoned.
- TX FIFO:
  - Write on tx_valid & tx_ready.
  - Read pointer advances only when the TX FSM loads the shifter.
  - Simultaneous write and read while full cannot occur, because tx_ready=0 when full.
  - Simultaneous write and read while empty is not allowed either: the FSM only loads from a non-empty FIFO, as registered at the previous edge.
- TX FSM states: IDLE → START → DATA → PARITY (skipped if PARITY=0) → STOP → IDLE or START.
  - Each state lasts CLKS_PER_BIT cycles per bit; DATA spans DATA_BITS bits, sent LSB first.
  - STOP lasts STOP_BITS bit periods.
  - Parity bit = XOR of the data bits (even), or its inverse (odd).
  - At the end of STOP, if the FIFO is non-empty, the FSM pops the next word and enters START directly, giving gapless back-to-back frames. Otherwise it goes to IDLE with tx=1.
- RX path:
  - rx passes through a 2-flop synchronizer. Decisions use the synchronized value (2 cycles of latency).
- RX FSM states: IDLE → START → DATA → PARITY (optional) → STOP → IDLE.
  - IDLE: a synchronized 1→0 transition enters START.
  - START: at cycle CLKS_PER_BIT/2 (integer divide) the line is resampled. If it is 1, the glitch is rejected and the FSM returns to IDLE. If it is 0, the baud counter restarts.
  - Subsequent samples are taken every CLKS_PER_BIT cycles, at bit centres.
  - At the stop-bit sample, the FSM loads rx_data and the error flags, pulses rx_valid on the next cycle, and returns to IDLE. It does not wait for the end of the stop bit, so the next start edge can be caught.
  - A framing error still produces rx_valid. The FSM waits in IDLE for the line to go 1 before re-arming edge detection.
- Frame length = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS bit periods.

## Timing
- TX accept edge k, with the FIFO empty and the FSM IDLE:
  - pop at edge k+1;
  - tx=0 from edge k+2 for CLKS_PER_BIT cycles.
- tx_ready deasserts the cycle after the FIFO reaches TX_FIFO_DEPTH entries. It reasserts the cycle after a pop.
- tx_busy falls the cycle tx returns to idle with the FIFO empty.
- RX latency: rx_valid pulses 1 cycle after the stop-bit centre sample, which is ~(frame_bits − 0.5)·CLKS_PER_BIT + 3 cycles after the rx falling edge.
- Reset mid-frame: tx=1 on the edge after reset is sampled low, and no rx_valid is produced for the abandoned frame.

## Test plan
- Reset: reset=0 for 4 cycles while tx_valid=1 → tx=1, tx_ready=1, tx_busy=0, rx_valid=0, and no word accepted.
- TX 8N1, CLKS_PER_BIT=8, send 0xA5 → tx bits 0,1,0,1,0,0,1,0,1,1, each held 8 cycles; frame 80 cycles; tx_busy=0 afterwards.
- FIFO back-pressure, depth 4: hold tx_valid with 6 words 0x01..0x06 →
  - 5 accepted in the first 6 cycles;
  - tx_ready low until the first frame's stop ends;
  - 6 frames emitted in order with no idle gap between stop and start.
- RX even parity, 8E1, CLKS_PER_BIT=8, drive 0x3C with parity 0 → one rx_valid pulse, rx_data=0x3C, both errors 0. Repeat with parity bit 1 → rx_parity_err=1, rx_data=0x3C.
- RX framing error: drive 0x55 with stop=0, then line high → rx_valid pulse with rx_frame_err=1; the next valid frame 0xAA is received with error 0.
- Glitch and mid-frame reset:
  - rx low for 3 cycles (CLKS_PER_BIT=8) → no rx_valid.
  - Assert reset midway through TX and RX frames → tx=1 next cycle, FIFO empty, no rx_valid.

Source files
------------

// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART with a TX FIFO,
// glitch-filtered RX and per-word parity/framing flags.
module uart_param #(
   parameter int CLKS_PER_BIT  = 434,
   parameter int DATA_BITS     = 8,
   parameter int PARITY        = 0,
   parameter int STOP_BITS     = 1,
   parameter int TX_FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic                 tx,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_busy,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam int AW = $clog2(TX_FIFO_DEPTH);

   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
   localparam logic [AW:0]   FIFO_FULL = (AW+1)'(TX_FIFO_DEPTH);

   localparam bit HAS_PAR = (PARITY != 0);
   localparam bit ODD_PAR = (PARITY == 2);

   // ---------------- TX FIFO ----------------
   logic [DATA_BITS-1:0] fifo_mem [TX_FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [AW:0]          fifo_cnt;
   logic                 push;
   logic                 pop;
   logic                 fifo_nempty;
   logic [DATA_BITS-1:0] fifo_head;

   assign tx_ready    = (fifo_cnt != FIFO_FULL);
   assign push        = tx_valid & tx_ready;
   assign fifo_nempty = (fifo_cnt != '0);
   assign fifo_head   = fifo_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= tx_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
            2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // ---------------- TX FSM ----------------
   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PAR,
      TX_STOP
   } tx_state_t;

   tx_state_t            tx_state;
   tx_state_t            tx_state_n;
   logic [CW-1:0]        tx_baud;
   logic [CW-1:0]        tx_baud_n;
   logic [BW-1:0]        tx_bit;
   logic [BW-1:0]        tx_bit_n;
   logic [DATA_BITS-1:0] tx_shift;
   logic [DATA_BITS-1:0] tx_shift_n;
   logic                 tx_par;
   logic                 tx_par_n;
   logic                 tx_line;
   logic                 tx_tick;
   logic                 tx_load;

   assign tx_tick = (tx_baud == BAUD_LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         tx_state <= TX_IDLE;
         tx_baud  <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx_par   <= 1'b0;
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
      end else begin
         tx_state <= tx_state_n;
         tx_baud  <= tx_baud_n;
         tx_bit   <= tx_bit_n;
         tx_shift <= tx_shift_n;
         tx_par   <= tx_par_n;
         tx       <= tx_line;
         tx_busy  <= (tx_state != TX_IDLE) | fifo_nempty;
      end
   end

   // tx is registered from the current state, so it trails the FSM by one cycle
   always_comb begin
      tx_state_n = tx_state;
      tx_baud_n  = tx_baud;
      tx_bit_n   = tx_bit;
      tx_shift_n = tx_shift;
      tx_par_n   = tx_par;
      tx_line    = 1'b1;
      tx_load    = 1'b0;
      pop        = 1'b0;
      unique case (tx_state)
         TX_IDLE: begin
            tx_baud_n = '0;
            tx_bit_n  = '0;
            tx_load   = fifo_nempty;
         end
         TX_START: begin
            tx_line   = 1'b0;
            tx_baud_n = tx_baud + CW'(1);
            if (tx_tick) begin
               tx_baud_n  = '0;
               tx_state_n = TX_DATA;
            end
         end
         TX_DATA: begin
            tx_line   = tx_shift[0];
            tx_baud_n = tx_baud + CW'(1);
            if (tx_tick) begin
               tx_baud_n  = '0;
               tx_shift_n = tx_shift >> 1;
               tx_bit_n   = tx_bit + BW'(1);
               if (tx_bit == DATA_LAST) begin
                  tx_bit_n   = '0;
                  tx_state_n = HAS_PAR ? TX_PAR : TX_STOP;
               end
            end
         end
         TX_PAR: begin
            tx_line   = tx_par;
            tx_baud_n = tx_baud + CW'(1);
            if (tx_tick) begin
               tx_baud_n  = '0;
               tx_state_n = TX_STOP;
            end
         end
         TX_STOP: begin
            tx_baud_n = tx_baud + CW'(1);
            if (tx_tick) begin
               tx_baud_n = '0;
               tx_bit_n  = tx_bit + BW'(1);
               if (tx_bit == STOP_LAST) begin
                  tx_bit_n   = '0;
                  tx_state_n = TX_IDLE;
                  tx_load    = fifo_nempty;
               end
            end
         end
         default: begin
            tx_state_n = TX_IDLE;
         end
      endcase
      if (tx_load) begin
         pop        = 1'b1;
         tx_shift_n = fifo_head;
         tx_par_n   = ^fifo_head ^ ODD_PAR;
         tx_state_n = TX_START;
      end
   end

   // ---------------- RX path ----------------
   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PAR,
      RX_STOP
   } rx_state_t;

   logic                 rx_s1;
   logic                 rx_s2;
   logic                 rx_s3;
   rx_state_t            rx_state;
   rx_state_t            rx_state_n;
   logic [CW-1:0]        rx_baud;
   logic [CW-1:0]        rx_baud_n;
   logic [BW-1:0]        rx_bit;
   logic [BW-1:0]        rx_bit_n;
   logic [DATA_BITS-1:0] rx_shift;
   logic [DATA_BITS-1:0] rx_shift_n;
   logic                 rx_par;
   logic                 rx_par_n;
   logic                 rx_tick;
   logic                 rx_done;

   assign rx_tick = (rx_baud == BAUD_LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_s1         <= 1'b1;
         rx_s2         <= 1'b1;
         rx_s3         <= 1'b1;
         rx_state      <= RX_IDLE;
         rx_baud       <= '0;
         rx_bit        <= '0;
         rx_shift      <= '0;
         rx_par        <= 1'b0;
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_frame_err  <= 1'b0;
      end else begin
         rx_s1    <= rx;
         rx_s2    <= rx_s1;
         rx_s3    <= rx_s2;
         rx_state <= rx_state_n;
         rx_baud  <= rx_baud_n;
         rx_bit   <= rx_bit_n;
         rx_shift <= rx_shift_n;
         rx_par   <= rx_par_n;
         rx_valid <= rx_done;
         if (rx_done) begin
            rx_data       <= rx_shift;
            rx_parity_err <= HAS_PAR & (rx_par ^ (^rx_shift) ^ ODD_PAR);
            rx_frame_err  <= ~rx_s2;
         end
      end
   end

   // a low stop bit leaves the line low, so the edge detector stays quiet until it rises
   always_comb begin
      rx_state_n = rx_state;
      rx_baud_n  = rx_baud;
      rx_bit_n   = rx_bit;
      rx_shift_n = rx_shift;
      rx_par_n   = rx_par;
      rx_done    = 1'b0;
      unique case (rx_state)
         RX_IDLE: begin
            rx_baud_n = '0;
            rx_bit_n  = '0;
            if (rx_s3 & ~rx_s2) begin
               rx_state_n = RX_START;
            end
         end
         RX_START: begin
            rx_baud_n = rx_baud + CW'(1);
            if (rx_baud == HALF_LAST) begin
               rx_baud_n  = '0;
               rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            rx_baud_n = rx_baud + CW'(1);
            if (rx_tick) begin
               rx_baud_n  = '0;
               rx_shift_n = {rx_s2, rx_shift[DATA_BITS-1:1]};
               rx_bit_n   = rx_bit + BW'(1);
               if (rx_bit == DATA_LAST) begin
                  rx_bit_n   = '0;
                  rx_state_n = HAS_PAR ? RX_PAR : RX_STOP;
               end
            end
         end
         RX_PAR: begin
            rx_baud_n = rx_baud + CW'(1);
            if (rx_tick) begin
               rx_baud_n  = '0;
               rx_par_n   = rx_s2;
               rx_state_n = RX_STOP;
            end
         end
         RX_STOP: begin
            rx_baud_n = rx_baud + CW'(1);
            if (rx_tick) begin
               rx_baud_n  = '0;
               rx_done    = 1'b1;
               rx_state_n = RX_IDLE;
            end
         end
         default: begin
            rx_state_n = RX_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_param.sv
// tb_uart_param: scoreboard bench; an 8N1 instance exercises TX,
// an 8E1 instance exercises RX, both at 8 clocks per bit.
module tb_uart_param;

   localparam int CPB = 8;

   logic       clk = 1'b0;
   logic       reset;

   logic       rx_n;
   logic       tx_n;
   logic [7:0] tx_data_n;
   logic       tx_valid_n;
   logic       tx_ready_n;
   logic       tx_busy_n;
   logic [7:0] rx_data_n;
   logic       rx_valid_n;
   logic       perr_n;
   logic       ferr_n;

   logic       rx_e;
   logic       tx_e;
   logic [7:0] tx_data_e;
   logic       tx_valid_e;
   logic       tx_ready_e;
   logic       tx_busy_e;
   logic [7:0] rx_data_e;
   logic       rx_valid_e;
   logic       perr_e;
   logic       ferr_e;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int tx_low_cnt = 0;
   int rx_pulses = 0;
   int rx_last = 0;
   int rx_fall = 0;
   logic tx_drop = 1'b0;

   logic [7:0] tx_q[$];
   logic [9:0] rx_q[$];
   int         tx_starts[$];

   uart_param #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0),
      .STOP_BITS(1), .TX_FIFO_DEPTH(4)
   ) dut_n (
      .clk(clk), .reset(reset), .rx(rx_n), .tx(tx_n),
      .tx_data(tx_data_n), .tx_valid(tx_valid_n),
      .tx_ready(tx_ready_n), .tx_busy(tx_busy_n),
      .rx_data(rx_data_n), .rx_valid(rx_valid_n),
      .rx_parity_err(perr_n), .rx_frame_err(ferr_n)
   );

   uart_param #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1),
      .STOP_BITS(1), .TX_FIFO_DEPTH(4)
   ) dut_e (
      .clk(clk), .reset(reset), .rx(rx_e), .tx(tx_e),
      .tx_data(tx_data_e), .tx_valid(tx_valid_e),
      .tx_ready(tx_ready_e), .tx_busy(tx_busy_e),
      .rx_data(rx_data_e), .rx_valid(rx_valid_e),
      .rx_parity_err(perr_e), .rx_frame_err(ferr_e)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tx_n === 1'b0) tx_low_cnt <= tx_low_cnt + 1;
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // bench-side UART decoder for the 8N1 TX line
   always begin : tx_mon
      logic [9:0] bits;
      logic       steady;
      logic [7:0] exp_d;
      int         t0;
      @(negedge clk);
      if (tx_n === 1'b0) begin
         t0 = cyc;
         steady = 1'b1;
         bits = '0;
         for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB; c++) begin
               if (b != 0 || c != 0) @(negedge clk);
               if (c == 0) bits[b] = tx_n;
               else if (tx_n !== bits[b]) steady = 1'b0;
            end
         end
         if (!tx_drop) begin
            tx_starts.push_back(t0);
            check("tx_queue", 32'(tx_q.size() > 0), 32'(1));
            if (tx_q.size() > 0) begin
               exp_d = tx_q.pop_front();
               check("tx_steady", 32'(steady), 32'(1));
               check("tx_frame", 32'(bits), 32'({1'b1, exp_d, 1'b0}));
            end
         end
      end
   end

   always @(negedge clk) begin : rx_mon
      logic [9:0] exp_r;
      if (rx_valid_e === 1'b1) begin
         rx_pulses++;
         rx_last = cyc;
         check("rx_queue", 32'(rx_q.size() > 0), 32'(1));
         if (rx_q.size() > 0) begin
            exp_r = rx_q.pop_front();
            check("rx_word", 32'({rx_data_e, perr_e, ferr_e}), 32'(exp_r));
         end
      end
   end

   task automatic tx_send(input logic [7:0] d, output int acc);
      int   n;
      logic rdy;
      n = 0;
      acc = -1;
      tx_data_n = d;
      tx_valid_n = 1'b1;
      while (acc < 0 && n < 500) begin
         @(negedge clk);
         rdy = tx_ready_n;
         @(posedge clk);
         #1;
         if (rdy === 1'b1) begin
            acc = cyc;
            tx_q.push_back(d);
         end
         n++;
      end
      check("tx_accept", 32'(acc >= 0), 32'(1));
   endtask

   task automatic wait_tx_done(input int budget);
      int n;
      n = 0;
      while ((tx_q.size() != 0 || tx_busy_n !== 1'b0) && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("tx_drain", tx_q.size(), 0);
      check("tx_busy_end", 32'(tx_busy_n), 32'(0));
   endtask

   task automatic rx_frame(input logic [7:0] d, input logic p, input logic s);
      logic [10:0] f;
      logic        pe;
      f = {s, p, d, 1'b0};
      pe = p ^ (^d);
      rx_q.push_back({d, pe, ~s});
      rx_fall = cyc;
      for (int i = 0; i < 11; i++) begin
         rx_e = f[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
      rx_e = 1'b1;
      repeat (2 * CPB) @(posedge clk);
      #1;
      check("rx_drain", rx_q.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a0;
      int p0;
      int base;
      int acc [6];
      reset = 1'b0;
      rx_n = 1'b1;
      rx_e = 1'b1;
      tx_valid_n = 1'b1;
      tx_data_n = 8'h77;
      tx_valid_e = 1'b0;
      tx_data_e = 8'h00;

      repeat (4) @(posedge clk);
      #1;
      check("rst_tx", 32'(tx_n), 32'(1));
      check("rst_ready", 32'(tx_ready_n), 32'(1));
      check("rst_busy", 32'(tx_busy_n), 32'(0));
      check("rst_rxv", 32'(rx_valid_e), 32'(0));
      check("rst_rxd", 32'(rx_data_e), 32'(0));
      check("rst_err", 32'({perr_e, ferr_e}), 32'(0));
      check("rst_other",
            32'({tx_e, tx_ready_e, tx_busy_e, rx_valid_n,
                 rx_data_n, perr_n, ferr_n}),
            32'({1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}));
      tx_valid_n = 1'b0;
      reset = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("rst_noacc", tx_low_cnt, 0);
      check("rst_idle_busy", 32'(tx_busy_n), 32'(0));

      tx_starts.delete();
      tx_send(8'hA5, a0);
      tx_valid_n = 1'b0;
      wait_tx_done(200);
      check("a5_nframes", tx_starts.size(), 1);
      check("a5_lat", (tx_starts.size() > 0) ? tx_starts[0] - a0 : -1, 2);

      tx_starts.delete();
      for (int i = 0; i < 6; i++) tx_send(8'(i + 1), acc[i]);
      tx_valid_n = 1'b0;
      check("bp_first5", acc[4] - acc[0], 4);
      check("bp_sixth", acc[5] - acc[0], 82);
      wait_tx_done(800);
      check("bp_nframes", tx_starts.size(), 6);
      for (int i = 1; i < tx_starts.size(); i++)
         check("bp_gap", tx_starts[i] - tx_starts[i-1], CPB * 10);

      p0 = rx_pulses;
      rx_frame(8'h3C, 1'b0, 1'b1);
      check("rx_lat", rx_last - rx_fall, 87);
      rx_frame(8'h3C, 1'b1, 1'b1);
      rx_frame(8'h55, 1'b0, 1'b0);
      rx_frame(8'hAA, 1'b0, 1'b1);
      check("rx_pulses", rx_pulses - p0, 4);

      p0 = rx_pulses;
      rx_e = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rx_e = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      check("glitch", rx_pulses - p0, 0);

      tx_drop = 1'b1;
      p0 = rx_pulses;
      tx_send(8'h11, a0);
      tx_send(8'h22, a0);
      tx_send(8'h33, a0);
      tx_valid_n = 1'b0;
      rx_e = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      reset = 1'b0;
      rx_e = 1'b1;
      @(posedge clk);
      #1;
      check("mid_tx", 32'(tx_n), 32'(1));
      check("mid_ready", 32'(tx_ready_n), 32'(1));
      check("mid_busy", 32'(tx_busy_n), 32'(0));
      check("mid_rxv", 32'(rx_valid_e), 32'(0));
      check("mid_rxd", 32'(rx_data_e), 32'(0));
      @(posedge clk);
      #1;
      reset = 1'b1;
      tx_q.delete();
      base = tx_low_cnt;
      repeat (120) @(posedge clk);
      #1;
      check("mid_fifo_empty", tx_low_cnt - base, 0);
      check("mid_no_rxv", rx_pulses - p0, 0);
      tx_drop = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
